// File: rtl/core_bus_pkg.sv
// Shared types and constants for the instruction fetch bus.
package core_bus_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } ibus_rsp_t;

    // One response pipeline slot: valid flag plus the payload it carries.
    typedef struct packed {
        logic      vld;
        ibus_rsp_t rsp;
    } ibus_stage_t;

    // Fibonacci taps 16,14,13,11 as a mask over state bits [15:0].
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_STALL_MASK   = 16'h0001;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random grant stalls.
module lfsr16
    import core_bus_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Program memory responder for the req/gnt/rvalid instruction fetch bus, with a
// backdoor load port, fixed read latency and an outstanding-request limit.
module instr_mem_responder
    import core_bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic        GNT_STALL       = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         instr_req,
    input  logic [31:0]                  instr_addr,
    output logic                         instr_gnt,
    output logic                         instr_rvalid,
    output logic [31:0]                  instr_rdata,
    output logic                         instr_err,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]                    mem [MEM_WORDS];
    logic [15:0]                    lfsr_state;
    logic                           stall;
    logic                           rsp_fire;
    logic [29:0]                    word_off;
    logic                           in_range;
    logic [AW-1:0]                  rd_idx;
    ibus_rsp_t                      rd_rsp;
    ibus_stage_t                    stage_in;
    ibus_stage_t [READ_LATENCY-1:0] pipe;
    logic [CW-1:0]                  outstanding;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .state   (lfsr_state)
    );

    assign stall    = GNT_STALL & (|(lfsr_state & LFSR_STALL_MASK));
    assign rsp_fire = pipe[READ_LATENCY-1].vld;

    // A response leaving this cycle frees a slot, so a full counter can still grant.
    assign instr_gnt = instr_req
                     & ((outstanding < CW'(MAX_OUTSTANDING)) | rsp_fire)
                     & ~stall;

    // Range check is unsigned and non-wrapping: addresses below the base are errors.
    always_comb begin
        word_off    = 30'((instr_addr - BASE_ADDR) >> 2);
        in_range    = (instr_addr >= BASE_ADDR) && (word_off < 30'(MEM_WORDS));
        rd_idx      = word_off[AW-1:0];
        rd_rsp.err  = ~in_range;
        rd_rsp.rdata = in_range ? mem[rd_idx] : 32'h0;
        stage_in.vld = instr_gnt;
        stage_in.rsp = instr_gnt ? rd_rsp : '0;
    end

    // Memory is deliberately not reset; the async read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (instr_gnt && !rsp_fire) begin
            outstanding <= outstanding + CW'(1);
        end else if (!instr_gnt && rsp_fire) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    // Response shift register; its last slot is the registered bus output.
    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pipe <= '0;
            end else begin
                pipe <= stage_in;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pipe <= '0;
            end else begin
                pipe <= {pipe[READ_LATENCY-2:0], stage_in};
            end
        end
    end

    assign instr_rvalid = pipe[READ_LATENCY-1].vld;
    assign instr_rdata  = pipe[READ_LATENCY-1].rsp.rdata;
    assign instr_err    = pipe[READ_LATENCY-1].rsp.err;

endmodule
